// File: rtl/ysyx_exu_bcast_arb_if.sv
// Signal bundle between the producer channels, the broadcast (CDB) ports and ysyx_exu_bcast_arb.
// The arbiter takes the slave view; the producer/consumer side takes the master view.
interface ysyx_exu_bcast_arb_if #(
    parameter int NCH  = 4,
    parameter int NBC  = 2,
    parameter int XLEN = 32,
    parameter int PLEN = 6,
    parameter int RLEN = 5,
    parameter int DW   = 5
);
    localparam int CW = $clog2(NCH);

    logic                 flush;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*DW-1:0]    in_dest;
    logic [NCH*PLEN-1:0]  in_prd;
    logic [NCH*RLEN-1:0]  in_rd;
    logic [NCH*XLEN-1:0]  in_result;
    logic [NCH-1:0]       in_trap;
    logic [NCH*XLEN-1:0]  in_cause;

    logic [NBC-1:0]       bc_valid;
    logic [NBC*DW-1:0]    bc_dest;
    logic [NBC*PLEN-1:0]  bc_prd;
    logic [NBC*RLEN-1:0]  bc_rd;
    logic [NBC*XLEN-1:0]  bc_result;
    logic [NBC-1:0]       bc_trap;
    logic [NBC*XLEN-1:0]  bc_cause;
    logic [NBC*CW-1:0]    bc_src;
    logic                 pending;

    modport master (
        output flush, in_valid, in_dest, in_prd, in_rd, in_result, in_trap, in_cause,
        input  in_ready, bc_valid, bc_dest, bc_prd, bc_rd, bc_result, bc_trap, bc_cause,
               bc_src, pending
    );

    modport slave (
        input  flush, in_valid, in_dest, in_prd, in_rd, in_result, in_trap, in_cause,
        output in_ready, bc_valid, bc_dest, bc_prd, bc_rd, bc_result, bc_trap, bc_cause,
               bc_src, pending
    );
endinterface

// File: rtl/ysyx_exu_bcast_arb.sv
// Result broadcast arbiter: per-producer FIFOs, round-robin grant of up to NBC heads per cycle
// onto registered CDB ports, with flush and a fairness pointer that resumes after the last grant.
module ysyx_exu_bcast_arb #(
    parameter int NCH   = 4,
    parameter int NBC   = 2,
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int PLEN  = 6,
    parameter int RLEN  = 5,
    parameter int DW    = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    ysyx_exu_bcast_arb_if.slave  io
);
    localparam int CW   = $clog2(NCH);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);
    localparam logic [CW-1:0]   LAST_CH = CW'(NCH - 1);

    typedef struct packed {
        logic [DW-1:0]   dest;
        logic [PLEN-1:0] prd;
        logic [RLEN-1:0] rd;
        logic [XLEN-1:0] result;
        logic            trap;
        logic [XLEN-1:0] cause;
    } pay_t;

    pay_t            mem    [NCH][DEPTH];
    logic [AW-1:0]   wr_ptr [NCH];
    logic [AW-1:0]   rd_ptr [NCH];
    logic [CNTW-1:0] count  [NCH];
    logic [CW-1:0]   rr_ptr;

    pay_t            bc_pay [NBC];
    logic [CW-1:0]   bc_src [NBC];
    logic [NBC-1:0]  bc_valid;

    pay_t            in_pay [NCH];
    logic [NCH-1:0]  nonempty;
    logic [NCH-1:0]  push;
    logic [NCH-1:0]  grant;
    logic [NBC-1:0]  port_vld;
    logic [CW-1:0]   port_ch [NBC];
    logic [CW-1:0]   last_ch;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign in_pay[c] = {io.in_dest[c*DW +: DW], io.in_prd[c*PLEN +: PLEN],
                            io.in_rd[c*RLEN +: RLEN], io.in_result[c*XLEN +: XLEN],
                            io.in_trap[c], io.in_cause[c*XLEN +: XLEN]};
        assign nonempty[c]    = (count[c] != '0);
        // Ready comes from the registered count only and is forced low while reset is held.
        assign io.in_ready[c] = reset && (count[c] != FULL);
        assign push[c]        = io.in_valid[c] && io.in_ready[c] && !io.flush;
    end

    always_comb begin : arb
        logic [NCH-1:0] avail;
        logic [CW-1:0]  ch;
        logic [CW-1:0]  sel;
        logic           found;
        // NOTE: every variable gets a default up front so no path can hold a stale value (no latch).
        avail    = nonempty;
        ch       = '0;
        sel      = '0;
        found    = 1'b0;
        grant    = '0;
        port_vld = '0;
        last_ch  = rr_ptr;
        for (int p = 0; p < NBC; p++) begin
            found = 1'b0;
            sel   = '0;
            // Walk the scan order backwards so the channel nearest rr_ptr is the one kept.
            for (int k = NCH - 1; k >= 0; k--) begin
                ch = CW'((int'(rr_ptr) + k) % NCH);
                if (avail[ch]) begin
                    sel   = ch;
                    found = 1'b1;
                end
            end
            port_ch[p]  = sel;
            port_vld[p] = found;
            if (found) begin
                grant[sel] = 1'b1;
                avail[sel] = 1'b0;
                last_ch    = sel;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else if (io.flush) begin
            rr_ptr <= '0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            if (|grant) rr_ptr <= (last_ch == LAST_CH) ? '0 : last_ch + CW'(1);
            for (int c = 0; c < NCH; c++) begin
                if (push[c])  wr_ptr[c] <= wr_ptr[c] + AW'(1);
                if (grant[c]) rd_ptr[c] <= rd_ptr[c] + AW'(1);
                count[c] <= count[c] + CNTW'(push[c]) - CNTW'(grant[c]);
            end
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers guard every read, so stale data never leaks.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= in_pay[c];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bc_valid <= '0;
            for (int p = 0; p < NBC; p++) begin
                bc_pay[p] <= '0;
                bc_src[p] <= '0;
            end
        end else begin
            bc_valid <= io.flush ? '0 : port_vld;
            for (int p = 0; p < NBC; p++) begin
                if (port_vld[p] && !io.flush) begin
                    bc_pay[p] <= mem[port_ch[p]][rd_ptr[port_ch[p]]];
                    bc_src[p] <= port_ch[p];
                end
            end
        end
    end

    for (genvar p = 0; p < NBC; p++) begin : g_bc
        assign io.bc_dest[p*DW +: DW]       = bc_pay[p].dest;
        assign io.bc_prd[p*PLEN +: PLEN]    = bc_pay[p].prd;
        assign io.bc_rd[p*RLEN +: RLEN]     = bc_pay[p].rd;
        assign io.bc_result[p*XLEN +: XLEN] = bc_pay[p].result;
        assign io.bc_trap[p]                = bc_pay[p].trap;
        assign io.bc_cause[p*XLEN +: XLEN]  = bc_pay[p].cause;
        assign io.bc_src[p*CW +: CW]        = bc_src[p];
    end

    assign io.bc_valid = bc_valid;
    assign io.pending  = |nonempty;

    always_ff @(posedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) assert (count[c] <= FULL);
        end
    end
endmodule
